// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame constants and counter sizing
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter that ticks on the last cycle of each bit
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);
  localparam int W = cnt_w(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLKS_PER_BIT - 1);
  assign pre_tick = cnt == W'(CLKS_PER_BIT - 2);
  // wrap on every bit boundary, hold at zero while cleared
  always_ff @(posedge clk) cnt <= clr || tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter with a one-byte holding buffer for gapless frames
module uart_tx_buffered import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  output logic       o_TX_Overflow
);
  tx_state_t state, state_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shifter, shift_n, hold;
  logic tick, pre_tick, acc, end_stop, load_buf, load_dir, to_buf, ready_n;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(i_Clk),
    .clr(i_Rst || state == IDLE),
    .tick(tick),
    .pre_tick(pre_tick)
  );
  assign acc = i_TX_DV && o_TX_Ready;
  assign end_stop = state == STOP && tick;
  assign load_buf = end_stop && !o_TX_Ready;
  assign load_dir = acc && (state == IDLE || end_stop);
  assign to_buf = acc && !load_dir;
  assign ready_n = load_buf || (o_TX_Ready && !to_buf);
  assign shift_n = load_buf ? hold : load_dir ? i_TX_Byte : state == DATA && tick ? shifter >> 1 : shifter;
  assign bit_n = state != DATA ? 3'd0 : tick ? bit_idx + 3'd1 : bit_idx;
  // frame sequencing; a finished stop bit chains straight into the next start bit when a byte is waiting
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = load_dir ? START : IDLE;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = tick && bit_idx == 3'(DATA_BITS - 1) ? STOP : DATA;
      default: state_n = !tick ? STOP : load_buf || load_dir ? START : IDLE;
    endcase
  end
  // all outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge i_Clk) begin
    shifter <= shift_n;
    if (to_buf) hold <= i_TX_Byte;
    if (i_Rst) begin
      state <= IDLE;
      bit_idx <= 3'd0;
      o_TX_Ready <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Done <= 1'b0;
      o_TX_Overflow <= 1'b0;
    end else begin
      state <= state_n;
      bit_idx <= bit_n;
      o_TX_Ready <= ready_n;
      o_TX_Active <= state_n != IDLE;
      o_TX_Serial <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
      o_TX_Done <= state == STOP && pre_tick;
      o_TX_Overflow <= i_TX_DV && !o_TX_Ready;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: frame-timing model, loopback receiver and random traffic against uart_tx_buffered
module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;
  logic clk = 0, rst = 1, dv = 0;
  logic [7:0] tx_byte = 0;
  logic ready, active, serial, done, ovf;
  int n_chk = 0, n_pass = 0;
  uart_tx_buffered #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
    .o_TX_Ready(ready), .o_TX_Active(active), .o_TX_Serial(serial),
    .o_TX_Done(done), .o_TX_Overflow(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic line_bit(input logic [7:0] b, input int t);
    return t < CPB ? 1'b0 : t < 9 * CPB ? b[3'((t - CPB) / CPB)] : 1'b1;
  endfunction
  bit m_init = 0, m_act = 0, m_full = 0, m_ovf = 0;
  int m_t = 0;
  logic [7:0] m_byte = 0, m_buf = 0;
  logic [7:0] sent_q[$];
  always @(posedge clk) begin
    bit a;
    if (rst) begin
      m_init = 1; m_act = 0; m_full = 0; m_ovf = 0;
      sent_q.delete();
    end else begin
      m_ovf = dv && m_full;
      a = dv && !m_full;
      if (m_act) begin
        m_t++;
        if (m_t == FRAME) begin
          m_t = 0;
          if (m_full) begin m_byte = m_buf; m_full = 0; sent_q.push_back(m_buf); end
          else if (a) begin m_byte = tx_byte; a = 0; sent_q.push_back(tx_byte); end
          else m_act = 0;
        end
      end else if (a) begin
        m_act = 1; m_t = 0; m_byte = tx_byte; a = 0; sent_q.push_back(tx_byte);
      end
      if (a) begin m_full = 1; m_buf = tx_byte; end
    end
  end
  always @(negedge clk) if (m_init) begin
    chk("serial", serial, m_act ? line_bit(m_byte, m_t) : 1'b1);
    chk("active", active, m_act);
    chk("ready", ready, !m_full);
    chk("done", done, m_act && m_t == FRAME - 1);
    chk("overflow", ovf, m_ovf);
  end
  bit rx_busy = 0;
  int rx_t = 0, rx_cnt = 0;
  logic [7:0] rx_byte = 0;
  always @(negedge clk) begin
    if (rst) rx_busy = 0;
    else if (!rx_busy) begin
      if (serial === 1'b0) begin rx_busy = 1; rx_t = 0; end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2 && rx_t > CPB && rx_t < 9 * CPB) rx_byte[3'((rx_t - CPB) / CPB)] = serial;
      if (rx_t == FRAME - 2) begin
        chk("rx_stop", serial, 1);
        chk("rx_byte", rx_byte, sent_q.size() > 0 ? {24'd0, sent_q.pop_front()} : 32'h100);
        rx_cnt++;
      end
      if (rx_t == FRAME - 1) rx_busy = 0;
    end
  end
  task automatic write(input logic [7:0] b);
    @(posedge clk); #1;
    dv = 1; tx_byte = b;
    @(posedge clk); #1;
    dv = 0; tx_byte = $urandom;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_serial", serial, 1);
    chk("rst_ready", ready, 1);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    write(8'h55);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k == 1) chk("x55_start", serial, 0);
      if (k == 5) chk("x55_bit0", serial, 1);
      if (k == 9) chk("x55_bit1", serial, 0);
      if (k == 36) chk("x55_bit7", serial, 0);
      if (k == 37) chk("x55_stop", serial, 1);
      if (k == 39) chk("x55_done_early", done, 0);
      if (k == 40) chk("x55_done", done, 1);
      if (k == 40) chk("x55_active_end", active, 1);
      if (k == 41) chk("x55_active_off", active, 0);
    end
    idle(3);
    write(8'hA3);
    idle(3);
    write(8'h0F);
    @(negedge clk);
    chk("buf_ready_low", ready, 0);
    idle(85);
    write(8'h11);
    write(8'h22);
    write(8'h33);
    @(negedge clk);
    chk("ovf_pulse", ovf, 1);
    chk("ovf_ready", ready, 0);
    @(negedge clk);
    chk("ovf_once", ovf, 0);
    idle(85);
    write(8'h96);
    idle(38);
    write(8'hC4);
    @(negedge clk);
    chk("chain_start", serial, 0);
    chk("chain_active", active, 1);
    idle(45);
    write(8'hFF);
    write(8'h81);
    idle(15);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_serial", serial, 1);
    chk("abort_ready", ready, 1);
    chk("abort_active", active, 0);
    idle(5);
    write(8'h81);
    idle(45);
    write(8'h00);
    write(8'hFF);
    idle(80);
    write(8'h5A);
    idle(45);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      dv = $urandom_range(0, 99) < (i < 1500 ? 6 : 20);
      tx_byte = $urandom;
      rst = $urandom_range(0, 599) == 0;
    end
    @(posedge clk); #1;
    dv = 0; rst = 0;
    idle(100);
    chk("drain_queue", sent_q.size(), 0);
    chk("drain_rx_idle", rx_busy, 0);
    chk("rx_seen", rx_cnt > 10, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
